// File: rtl/max6675_pkg.sv
// Shared types and MAX6675 frame layout for the thermocouple scanner.
package max6675_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        DESELECT,
        NEXT,
        WAIT
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int DUMMY      = 15;
    localparam int TEMP_MSB   = 14;
    localparam int TEMP_LSB   = 3;
    localparam int OPEN       = 2;
    localparam int ID         = 1;
    localparam int TEMP_W     = TEMP_MSB - TEMP_LSB + 1;

    // Dummy sign bit and device ID bit both read 0 on a healthy bus.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return !f[DUMMY] && !f[ID];
    endfunction

endpackage

// File: rtl/max6675_tick.sv
// Free-running divider: one-cycle tick every DIVIDER clocks.
module max6675_tick #(
    parameter int DIVIDER = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(DIVIDER - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/max6675_scanner.sv
// Round-robin reader for several MAX6675 devices on a shared SCLK/MISO bus,
// holding the last good temperature/open flag per channel.
module max6675_scanner
    import max6675_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DIVIDER    = 1000,
    parameter int CONV_TICKS = 12000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    miso,
    output logic                    sclk,
    output logic [CHANNELS-1:0]     cs_n,
    output logic [12*CHANNELS-1:0]  temperature,
    output logic [CHANNELS-1:0]     open_tc,
    output logic [CHANNELS-1:0]     valid,
    output logic                    scan_done,
    output logic                    frame_err
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WT_W  = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic tick;

    max6675_tick #(.DIVIDER(DIVIDER)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    state_e                           state_q, state_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [BIT_W-1:0]                 bit_q, bit_d;
    logic [WT_W-1:0]                  wcnt_q, wcnt_d;
    logic [FRAME_BITS-1:0]            sr_q, sr_d;
    logic                             sclk_q, sclk_d;
    logic                             stop_q, stop_d;
    logic [CHANNELS-1:0][TEMP_W-1:0]  temp_q, temp_d;
    logic [CHANNELS-1:0]              open_q, open_d;
    logic [CHANNELS-1:0]              valid_q, valid_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;

    logic sel_act;
    assign sel_act = (state_q == SELECT) || (state_q == SHIFT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cs
        assign cs_n[i] = ~(sel_act && (ch_q == CH_W'(i)));
    end

    assign sclk        = sclk_q;
    assign temperature = temp_q;
    assign open_tc     = open_q;
    assign valid       = valid_q;
    assign scan_done   = done_q;
    assign frame_err   = err_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        wcnt_d  = wcnt_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        stop_d  = stop_q;
        temp_d  = temp_q;
        open_d  = open_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Enable loss mid-frame lets the frame finish, then ends the scan.
        if (sel_act && !enable) stop_d = 1'b1;

        if (tick) begin
            unique case (state_q)
                IDLE: if (enable) begin
                    state_d = SELECT;
                    ch_d    = '0;
                    stop_d  = 1'b0;
                end
                SELECT: begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end
                SHIFT: if (!sclk_q) begin
                    sclk_d = 1'b1;
                    sr_d   = {sr_q[FRAME_BITS-2:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = DESELECT;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
                DESELECT: begin
                    if (frame_ok(sr_q)) begin
                        temp_d[ch_q]  = sr_q[TEMP_MSB:TEMP_LSB];
                        open_d[ch_q]  = sr_q[OPEN];
                        valid_d[ch_q] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = stop_q ? IDLE : NEXT;
                end
                NEXT: if (ch_q != CH_W'(CHANNELS - 1)) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = SELECT;
                end else begin
                    done_d  = 1'b1;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
                WAIT: if (wcnt_q == WT_W'(CONV_TICKS - 1)) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + WT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            bit_q   <= '0;
            wcnt_q  <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            stop_q  <= 1'b0;
            temp_q  <= '0;
            open_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            wcnt_q  <= wcnt_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            stop_q  <= stop_d;
            temp_q  <= temp_d;
            open_q  <= open_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
